// File: rtl/loader_pkg.sv
// Shared types for the program loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : bytes assembled into one RAM word
//   word_addr()    : byte address of word idx above a word-aligned base, mod 2^32
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    VERIFY,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word.
//   clk, rst_n      : clock, async active-low reset
//   i_accept        : byte handshake strobe
//   i_byte          : byte to place in the current lane
//   i_clear         : restart at lane 0
//   o_word_valid    : the byte accepted this cycle completes the word
//   o_word          : assembled word (stable until the next accept)
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_clear,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_word[{r_byte_cnt, 3'b000} +: 8] <= i_byte;
      // wraps to lane 0 after the last byte, ready for the next word
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word_valid = i_accept && (r_byte_cnt == LAST_LANE);
  assign o_word       = r_word;

endmodule

// File: rtl/mem_loader.sv
// Program loader: streams bytes into RAM port 2 as 32-bit words, optionally
// reads each word back, and holds the core in reset until the image is in.
//   clk, rst_n            : clock, async active-low reset
//   start                 : one-cycle load request (ignored while busy)
//   base_addr, num_words  : image placement and length in words
//   s_valid/s_data/s_ready: byte stream, LSB first
//   mem_addr/we/wd/rd     : RAM port 2 (rd is a combinational read of addr)
//   core_rst_n            : released only after a successful load
//   busy, done, err       : load status (done/err are levels)
module mem_loader
  import loader_pkg::loader_state_t, loader_pkg::IDLE, loader_pkg::RECV,
         loader_pkg::WRITE, loader_pkg::DONE, loader_pkg::ERR, loader_pkg::word_addr;
#(
  parameter int CNT_W  = 16,
  parameter bit VERIFY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  loader_state_t    r_state;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_word_idx;

  logic        w_accept;
  logic        w_restart;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_advance;

  assign w_accept  = s_valid && s_ready;
  assign w_restart = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_last    = (r_word_idx == r_num - CNT_W'(1));
  // VERIFY state name is shadowed by the parameter, hence the scoped reference
  assign w_advance = ((r_state == WRITE) && !VERIFY) ||
                     ((r_state == loader_pkg::VERIFY) && (mem_rd == w_word));

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_accept     (w_accept),
    .i_byte       (s_data),
    .i_clear      (w_restart),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // the packer buffer only changes in RECV, so it doubles as the write data
  assign mem_wd = w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_word_idx <= '0;
      s_ready    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_base     <= base_addr & ~32'h3;
            r_num      <= num_words;
            r_word_idx <= '0;
            err        <= 1'b0;
            if (num_words == '0) begin
              r_state    <= DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
              busy       <= 1'b0;
            end else begin
              r_state    <= RECV;
              s_ready    <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              core_rst_n <= 1'b0;
            end
          end
        end
        RECV: begin
          if (w_word_valid) begin
            r_state  <= WRITE;
            s_ready  <= 1'b0;
            mem_we   <= 1'b1;
            mem_addr <= word_addr(r_base, 32'(r_word_idx));
          end
        end
        WRITE: begin
          if (VERIFY) r_state <= loader_pkg::VERIFY;
        end
        loader_pkg::VERIFY: begin
          if (mem_rd != w_word) begin
            r_state <= ERR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_advance) begin
        if (w_last) begin
          r_state    <= DONE;
          done       <= 1'b1;
          core_rst_n <= 1'b1;
          busy       <= 1'b0;
        end else begin
          r_state    <= RECV;
          r_word_idx <= r_word_idx + CNT_W'(1);
          s_ready    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] ram [64];
  logic        bad_rd = 1'b0;
  int          we_cnt = 0;
  bit          sready_seen = 1'b0;
  logic [31:0] wr_addr_q [$];

  int checks = 0;
  int errors = 0;

  mem_loader #(.CNT_W(16), .VERIFY(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign mem_rd = bad_rd ? 32'hDEADBEEF : ram[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wd;
      we_cnt++;
      wr_addr_q.push_back(mem_addr);
    end
    if (s_ready) sready_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns on the negedge just after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    forever begin
      if (rnd && ($urandom_range(1, 0) == 0)) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = b;
        if (s_ready) begin
          @(negedge clk);
          s_valid = 1'b0;
          return;
        end
      end
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("byte_timeout", 32'(guard), 32'd200);
        s_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_words [4];
    stall_words[0] = 32'hA1B2C3D4;
    stall_words[1] = 32'h00FF00FF;
    stall_words[2] = 32'h80000001;
    stall_words[3] = 32'h5A5AA5A5;
    foreach (ram[i]) ram[i] = '0;

    // reset values
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic load
    we_cnt = 0;
    pulse_start(32'h8, 16'd3);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_s_ready", 32'(s_ready), 32'd1);
    send_word(32'h00832303, 1'b0);
    send_word(32'h00602623, 1'b0);
    send_word(32'h12345678, 1'b0);
    chk("basic_last_we", 32'(mem_we), 32'd1);
    chk("basic_last_addr", mem_addr, 32'h10);
    chk("basic_last_wd", mem_wd, 32'h12345678);
    @(negedge clk);
    chk("basic_verify_we", 32'(mem_we), 32'd0);
    chk("basic_verify_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("basic_busy_off", 32'(busy), 32'd0);
    chk("basic_ram08", ram[2], 32'h00832303);
    chk("basic_ram0c", ram[3], 32'h00602623);
    chk("basic_ram10", ram[4], 32'h12345678);
    chk("basic_we_cnt", 32'(we_cnt), 32'd3);

    // stalled stream
    we_cnt = 0;
    pulse_start(32'h40, 16'd4);
    for (int w = 0; w < 4; w++) send_word(stall_words[w], 1'b1);
    wait_done("stall_done");
    for (int w = 0; w < 4; w++) chk($sformatf("stall_ram%0d", w), ram[16 + w], stall_words[w]);
    chk("stall_we_cnt", 32'(we_cnt), 32'd4);

    // verify failure on the second word
    we_cnt = 0;
    pulse_start(32'h80, 16'd3);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    bad_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bad_rd = 1'b0;
    chk("vfail_err", 32'(err), 32'd1);
    chk("vfail_done", 32'(done), 32'd0);
    chk("vfail_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("vfail_busy", 32'(busy), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'h33;
    repeat (6) @(negedge clk);
    s_valid = 1'b0;
    chk("vfail_we_cnt", 32'(we_cnt), 32'd2);
    chk("vfail_s_ready", 32'(s_ready), 32'd0);

    // zero-length restart from ERR
    we_cnt = 0;
    sready_seen = 1'b0;
    pulse_start(32'h0, 16'd0);
    chk("zero_err_cleared", 32'(err), 32'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("zero_we_cnt", 32'(we_cnt), 32'd0);
    chk("zero_s_ready_seen", 32'(sready_seen), 32'd0);

    // reset mid-load, then a fresh load from lane 0 (base low bits ignored)
    pulse_start(32'h21, 16'd4);
    send_word(32'hAABBCCDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_mem_addr", mem_addr, 32'd0);
    chk("mrst_mem_wd", mem_wd, 32'd0);
    chk("mrst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_partial_ram", ram[8], 32'hAABBCCDD);
    @(negedge clk);
    rst_n = 1'b1;
    wr_addr_q.delete();
    pulse_start(32'h31, 16'd1);
    send_word(32'h44332211, 1'b0);
    wait_done("mrst_reload_done");
    chk("mrst_reload_ram", ram[12], 32'h44332211);
    chk("mrst_reload_addr", wr_addr_q[0], 32'h30);

    // address wrap, start ignored while busy
    we_cnt = 0;
    wr_addr_q.delete();
    pulse_start(32'hFFFFFFFC, 16'd2);
    start = 1'b1;
    base_addr = 32'h100;
    num_words = 16'd1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'hCAFEF00D, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'h0BADC0DE, 1'b0);
    wait_done("wrap_done");
    chk("wrap_we_cnt", 32'(we_cnt), 32'd2);
    chk("wrap_addr0", wr_addr_q[0], 32'hFFFFFFFC);
    chk("wrap_addr1", wr_addr_q[1], 32'h0);
    chk("wrap_ram_top", ram[63], 32'hCAFEF00D);
    chk("wrap_ram_zero", ram[0], 32'h0BADC0DE);
    chk("wrap_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
